pcie_seg_stream_monitor: RTL and testbench

Passive, synthesizable protocol monitor for the segmented Avalon-ST TLP streams (rx_st_* / tx_st_*) between the PCIe hard IP and fpga_core. It is parametrised in segment count, segment width and ready latency. It tracks packet framing across segments and cycles, and checks TLP length against the header Length field. It reports counters and sticky error flags to the bench and to on-chip debug logic. One instance is attached per stream direction in the top-level testbench and, optionally, in the FPGA build.

---
 rtl/pcie_seg_stream_monitor_pkg.sv | 30 +++
 rtl/pcie_seg_stream_monitor_if.sv | 29 ++
 rtl/pcie_seg_stream_monitor_st_ready_delay.sv | 33 +++
 rtl/pcie_seg_stream_monitor.sv | 161 ++++++++++++++++
 tb/tb_pcie_seg_stream_monitor.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_seg_stream_monitor_pkg.sv
// Shared definitions for the segmented Avalon-ST TLP stream monitor:
// error bit positions, per-segment framing state and TLP length decode.
package pcie_mon_pkg;

    localparam int ERR_SOP_IN_PKT   = 0;
    localparam int ERR_NO_SOP       = 1;
    localparam int ERR_READY_VIOL   = 2;
    localparam int ERR_EMPTY_NO_EOP = 3;
    localparam int ERR_LEN_MISMATCH = 4;
    localparam int ERR_W            = 5;

    localparam logic [10:0] DW_ACC_MAX = 11'd2047;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } seg_state_t;

    // Total DWs a TLP should occupy: header (3 or 4 DW) plus payload when fmt says "with data".
    function automatic logic [10:0] tlp_expected_dw(input logic [31:0] dw0);
        logic [2:0]  fmt;
        logic [10:0] len;
        logic [10:0] hdr;
        fmt = dw0[31:29];
        len = (dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0[9:0]};
        hdr = fmt[0] ? 11'd4 : 11'd3;
        return hdr + (fmt[1] ? len : 11'd0);
    endfunction

endpackage

// File: rtl/pcie_seg_stream_monitor_if.sv
// Segmented Avalon-ST TLP stream bundle; the monitor attaches through the
// all-input monitor modport.
interface pcie_seg_stream_monitor_if #(
    parameter int SEG_COUNT       = 2,
    parameter int SEG_DATA_WIDTH  = 256,
    parameter int SEG_EMPTY_WIDTH = $clog2(SEG_DATA_WIDTH/32)
);
    logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]  st_data;
    logic [SEG_COUNT*SEG_EMPTY_WIDTH-1:0] st_empty;
    logic [SEG_COUNT-1:0]                 st_sop;
    logic [SEG_COUNT-1:0]                 st_eop;
    logic [SEG_COUNT-1:0]                 st_valid;
    logic                                 st_ready;

    modport master (
        output st_data, st_empty, st_sop, st_eop, st_valid,
        input  st_ready
    );

    modport slave (
        input  st_data, st_empty, st_sop, st_eop, st_valid,
        output st_ready
    );

    modport monitor (
        input st_data, st_empty, st_sop, st_eop, st_valid, st_ready
    );

endinterface

// File: rtl/pcie_seg_stream_monitor_st_ready_delay.sv
// Delays st_ready by READY_LATENCY cycles to give the cycle in which the
// source is permitted to assert st_valid.
module st_ready_delay #(
    parameter int READY_LATENCY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ready,
    output logic o_permitted
);

    generate
        if (READY_LATENCY == 0) begin : g_bypass
            assign o_permitted = i_ready;
        end else begin : g_delay
            logic [READY_LATENCY-1:0] r_sr;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sr <= '0;
                end else begin
                    r_sr[0] <= i_ready;
                    for (int unsigned i = 1; i < READY_LATENCY; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign o_permitted = r_sr[READY_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/pcie_seg_stream_monitor.sv
// Passive monitor for segmented PCIe TLP streams: tracks framing across
// segments/cycles, checks length against DW0, counts TLPs/DWs, flags errors.
module pcie_seg_stream_monitor
    import pcie_mon_pkg::*;
#(
    parameter int SEG_COUNT       = 2,
    parameter int SEG_DATA_WIDTH  = 256,
    parameter int SEG_EMPTY_WIDTH = $clog2(SEG_DATA_WIDTH/32),
    parameter int READY_LATENCY   = 3,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    pcie_seg_stream_monitor_if.monitor st,
    input  logic                     clear,
    output logic [CNT_WIDTH-1:0]     tlp_count,
    output logic [CNT_WIDTH-1:0]     dw_count,
    output logic [ERR_W-1:0]         err_sticky,
    output logic                     err_pulse,
    output logic [CNT_WIDTH-1:0]     first_err_cycle,
    output logic                     in_pkt
);

    localparam logic [10:0]          SEG_DW  = 11'(SEG_DATA_WIDTH/32);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    seg_state_t                 r_state, w_state_nxt;
    logic [10:0]                r_exp, w_exp_nxt;
    logic [10:0]                r_acc, w_acc_nxt;
    logic [10:0]                w_obs;
    logic [SEG_EMPTY_WIDTH-1:0] w_empty;
    logic [ERR_W-1:0]           w_err;
    logic [CNT_WIDTH-1:0]       w_tlp_nxt, w_dw_nxt;
    logic [CNT_WIDTH-1:0]       r_tlp, r_dw, r_cycle, r_first;
    logic [ERR_W-1:0]           r_err;
    logic                       r_pulse;
    logic                       w_permitted;
    logic                       w_unused_data;

    // Only DW0 of each segment is decoded; the rest of the payload is observed but not checked.
    assign w_unused_data = ^st.st_data;

    function automatic logic [CNT_WIDTH-1:0] cnt_add_sat(
        input logic [CNT_WIDTH-1:0] a,
        input logic [10:0]          b
    );
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + (CNT_WIDTH+1)'(b);
        return sum[CNT_WIDTH] ? CNT_MAX : sum[CNT_WIDTH-1:0];
    endfunction

    function automatic logic [10:0] acc_add_sat(input logic [10:0] a, input logic [10:0] b);
        logic [11:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[11] ? DW_ACC_MAX : sum[10:0];
    endfunction

    st_ready_delay #(
        .READY_LATENCY (READY_LATENCY)
    ) u_ready_delay (
        .clk         (clk),
        .rst         (rst),
        .i_ready     (st.st_ready),
        .o_permitted (w_permitted)
    );

    // Segment state ripples from segment 0 upward so several TLPs may start/end in one beat.
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_acc_nxt   = r_acc;
        w_obs       = '0;
        w_empty     = '0;
        w_err       = '0;
        w_tlp_nxt   = r_tlp;
        w_dw_nxt    = r_dw;

        w_err[ERR_READY_VIOL] = (|st.st_valid) && !w_permitted;

        for (int unsigned s = 0; s < SEG_COUNT; s++) begin
            if (st.st_valid[s]) begin
                w_empty = st.st_empty[s*SEG_EMPTY_WIDTH +: SEG_EMPTY_WIDTH];
                w_obs   = st.st_eop[s] ? SEG_DW - 11'(w_empty) : SEG_DW;

                if ((w_empty != '0) && !st.st_eop[s]) begin
                    w_err[ERR_EMPTY_NO_EOP] = 1'b1;
                end

                if (st.st_sop[s]) begin
                    if (w_state_nxt == PKT) begin
                        w_err[ERR_SOP_IN_PKT] = 1'b1;
                    end
                    w_exp_nxt   = tlp_expected_dw(st.st_data[s*SEG_DATA_WIDTH +: 32]);
                    w_acc_nxt   = w_obs;
                    w_state_nxt = PKT;
                end else if (w_state_nxt == PKT) begin
                    w_acc_nxt = acc_add_sat(w_acc_nxt, w_obs);
                end else begin
                    w_err[ERR_NO_SOP] = 1'b1;
                end

                if (st.st_eop[s] && (w_state_nxt == PKT)) begin
                    if (w_acc_nxt != w_exp_nxt) begin
                        w_err[ERR_LEN_MISMATCH] = 1'b1;
                    end
                    w_tlp_nxt   = cnt_add_sat(w_tlp_nxt, 11'd1);
                    w_dw_nxt    = cnt_add_sat(w_dw_nxt, w_acc_nxt);
                    w_state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_exp   <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    // Clear drops this cycle's completions but keeps this cycle's errors as the new first error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle <= '0;
            r_tlp   <= '0;
            r_dw    <= '0;
            r_err   <= '0;
            r_pulse <= 1'b0;
            r_first <= '0;
        end else begin
            r_cycle <= (r_cycle == CNT_MAX) ? r_cycle : r_cycle + 1'b1;
            r_pulse <= |w_err;
            if (clear) begin
                r_tlp   <= '0;
                r_dw    <= '0;
                r_err   <= w_err;
                r_first <= (|w_err) ? r_cycle : '0;
            end else begin
                r_tlp <= w_tlp_nxt;
                r_dw  <= w_dw_nxt;
                r_err <= r_err | w_err;
                if ((r_err == '0) && (|w_err)) begin
                    r_first <= r_cycle;
                end
            end
        end
    end

    assign tlp_count       = r_tlp;
    assign dw_count        = r_dw;
    assign err_sticky      = r_err;
    assign err_pulse       = r_pulse;
    assign first_err_cycle = r_first;
    assign in_pkt          = (r_state == PKT);

endmodule

// File: tb/tb_pcie_seg_stream_monitor.sv
// Directed and randomized checks of pcie_seg_stream_monitor against a
// TLP-level reference model kept in the bench.
module tb_pcie_seg_stream_monitor;

    localparam int SC = 2;
    localparam int SW = 256;
    localparam int EW = 3;
    localparam int RL = 3;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic [CW-1:0] tlp_count, dw_count, first_err_cycle;
    logic [4:0]    err_sticky;
    logic          err_pulse, in_pkt;

    pcie_seg_stream_monitor_if #(.SEG_COUNT(SC), .SEG_DATA_WIDTH(SW), .SEG_EMPTY_WIDTH(EW)) stif();

    pcie_seg_stream_monitor #(
        .SEG_COUNT(SC), .SEG_DATA_WIDTH(SW), .SEG_EMPTY_WIDTH(EW),
        .READY_LATENCY(RL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .st(stif), .clear(clear),
        .tlp_count(tlp_count), .dw_count(dw_count), .err_sticky(err_sticky),
        .err_pulse(err_pulse), .first_err_cycle(first_err_cycle), .in_pkt(in_pkt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Segment stimulus for the current beat
    bit          g_v[SC], g_sop[SC], g_eop[SC];
    int          g_em[SC];
    logic [31:0] g_dw0[SC];

    // Reference model state
    bit     m_inpkt;
    int     m_exp, m_acc;
    int     m_done[$];
    bit     m_rdy[$];
    int     m_err;
    bit     m_pulse;
    longint m_first, m_cyc;

    function automatic int tlp_len(logic [31:0] dw0);
        int fmt, len;
        fmt = int'(dw0[31:29]);
        len = int'(dw0[9:0]);
        if (len == 0) len = 1024;
        return ((fmt % 2) ? 4 : 3) + (((fmt / 2) % 2) ? len : 0);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_inpkt = 0; m_exp = 0; m_acc = 0; m_done.delete(); m_rdy.delete();
        m_err = 0; m_pulse = 0; m_first = 0; m_cyc = 0;
    endtask

    task automatic check_all(string tag);
        longint sum = 0;
        foreach (m_done[i]) sum += m_done[i];
        chk({tag, ".tlp_count"}, tlp_count, 32'(m_done.size()));
        chk({tag, ".dw_count"}, dw_count, 32'(sum));
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_err));
        chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
        chk({tag, ".first_err_cycle"}, first_err_cycle, 32'(m_first));
        chk({tag, ".in_pkt"}, 32'(in_pkt), 32'(m_inpkt));
    endtask

    task automatic seg_idle();
        for (int s = 0; s < SC; s++) begin
            g_v[s] = 0; g_sop[s] = 0; g_eop[s] = 0; g_em[s] = 0; g_dw0[s] = '0;
        end
    endtask

    task automatic seg(int s, bit sop, bit eop, int em, logic [31:0] dw0);
        g_v[s] = 1; g_sop[s] = sop; g_eop[s] = eop; g_em[s] = em; g_dw0[s] = dw0;
    endtask

    task automatic apply();
        logic [SW-1:0] d;
        for (int s = 0; s < SC; s++) begin
            for (int k = 0; k < SW / 32; k++) d[k*32 +: 32] = $urandom;
            d[31:0] = g_dw0[s];
            stif.st_data[s*SW +: SW]  = d;
            stif.st_empty[s*EW +: EW] = EW'(g_em[s]);
            stif.st_sop[s]   = g_sop[s];
            stif.st_eop[s]   = g_eop[s];
            stif.st_valid[s] = g_v[s];
        end
    endtask

    // One beat of the reference: TLP boundaries and sticky/first-error bookkeeping.
    task automatic model_eval();
        int  errs = 0;
        int  now_done[$];
        bit  perm;
        int  obs;
        perm = (m_rdy.size() >= RL) ? m_rdy[RL-1] : 1'b0;
        if ((g_v[0] || g_v[1]) && !perm) errs |= 4;
        for (int s = 0; s < SC; s++) begin
            if (!g_v[s]) continue;
            obs = g_eop[s] ? (SW / 32 - g_em[s]) : SW / 32;
            if (g_em[s] != 0 && !g_eop[s]) errs |= 8;
            if (g_sop[s]) begin
                if (m_inpkt) errs |= 1;
                m_exp = tlp_len(g_dw0[s]);
                m_acc = obs;
                m_inpkt = 1;
            end else if (m_inpkt) begin
                m_acc = (m_acc + obs > 2047) ? 2047 : m_acc + obs;
            end else begin
                errs |= 2;
                continue;
            end
            if (g_eop[s]) begin
                if (m_acc != m_exp) errs |= 16;
                now_done.push_back(m_acc);
                m_inpkt = 0;
            end
        end
        if (clear) begin
            m_done.delete();
            m_err = errs;
            m_first = (errs != 0) ? m_cyc : 0;
        end else begin
            foreach (now_done[i]) m_done.push_back(now_done[i]);
            if (m_err == 0 && errs != 0) m_first = m_cyc;
            m_err |= errs;
        end
        m_pulse = (errs != 0);
    endtask

    task automatic step(string tag);
        apply();
        model_eval();
        @(posedge clk);
        #1;
        m_rdy.push_front(stif.st_ready);
        if (m_rdy.size() > 8) void'(m_rdy.pop_back());
        m_cyc++;
        check_all(tag);
        seg_idle();
        clear = 0;
    endtask

    task automatic random_beat();
        for (int s = 0; s < SC; s++) begin
            bit v, so, eo;
            int em;
            logic [31:0] d0;
            v  = ($urandom % 4) != 0;
            so = ($urandom % 100) < 35;
            eo = ($urandom % 100) < 40;
            if (eo) em = ($urandom % 2) ? int'($urandom % 8) : 0;
            else    em = (($urandom % 20) == 0) ? int'(1 + $urandom % 7) : 0;
            d0 = $urandom;
            d0[9:0] = (($urandom % 16) == 0) ? 10'd0 : 10'(1 + $urandom % 12);
            if (v) seg(s, so, eo, em, d0);
        end
    endtask

    longint viol_cyc;

    initial begin
        stif.st_ready = 1'b1;
        seg_idle();
        model_reset();

        // Reset held with random traffic
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            random_beat();
            stif.st_ready = 1'($urandom);
            apply();
            @(posedge clk);
            #1;
            check_all("reset");
        end
        seg_idle();
        apply();
        stif.st_ready = 1'b1;
        rst = 1;
        model_reset();
        for (int i = 0; i < 4; i++) step("post_reset");

        // MWr 4DW len 4 in one segment
        seg(0, 1, 1, 0, 32'h6000_0004);
        step("mwr4");
        chk("mwr4.tlp", tlp_count, 1);
        chk("mwr4.dw", dw_count, 8);
        chk("mwr4.err", 32'(err_sticky), 0);

        // Two MRd 3DW in one beat
        clear = 1; step("clr_a");
        seg(0, 1, 1, 5, 32'h0000_0001);
        seg(1, 1, 1, 5, 32'h0000_0001);
        step("two_mrd");
        chk("two_mrd.tlp", tlp_count, 2);
        chk("two_mrd.dw", dw_count, 6);
        chk("two_mrd.in_pkt", 32'(in_pkt), 0);

        // MWr 3DW len 16 across two beats
        clear = 1; step("clr_b");
        seg(0, 1, 0, 0, 32'h4000_0010);
        seg(1, 0, 0, 0, 32'h0);
        step("mwr16_a");
        chk("mwr16_a.in_pkt", 32'(in_pkt), 1);
        seg(0, 0, 1, 5, 32'h0);
        step("mwr16_b");
        chk("mwr16_b.tlp", tlp_count, 1);
        chk("mwr16_b.dw", dw_count, 19);

        // Ready dropped for one cycle: valid 2 cycles later is fine, 3 later is a violation
        stif.st_ready = 0; step("rdy_low");
        stif.st_ready = 1; step("rdy_gap");
        seg(0, 1, 1, 5, 32'h0000_0001);
        step("rdy_ok");
        chk("rdy_ok.err", 32'(err_sticky), 0);
        viol_cyc = m_cyc;
        seg(0, 1, 1, 5, 32'h0000_0001);
        step("rdy_viol");
        chk("rdy_viol.err", 32'(err_sticky), 32'h4);
        chk("rdy_viol.pulse", 32'(err_pulse), 1);
        chk("rdy_viol.first", first_err_cycle, 32'(viol_cyc));
        step("rdy_after");
        chk("rdy_after.pulse", 32'(err_pulse), 0);

        // Length mismatch, then sop inside a packet, then clear
        clear = 1; step("clr_c");
        seg(0, 1, 1, 1, 32'h6000_0004);
        step("len_mis");
        chk("len_mis.err", 32'(err_sticky), 32'h10);
        chk("len_mis.tlp", tlp_count, 1);
        seg(0, 1, 0, 0, 32'h4000_0010);
        step("open");
        seg(1, 1, 0, 0, 32'h4000_0010);
        step("sop_in_pkt");
        chk("sop_in_pkt.err0", 32'(err_sticky[0]), 1);
        clear = 1; step("clr_d");
        chk("clr_d.tlp", tlp_count, 0);
        chk("clr_d.err", 32'(err_sticky), 0);
        chk("clr_d.in_pkt", 32'(in_pkt), 1);

        // Error coinciding with clear survives it
        viol_cyc = m_cyc;
        seg(0, 0, 0, 2, 32'h0);
        clear = 1; step("clr_err");
        chk("clr_err.err", 32'(err_sticky), 32'h8);
        chk("clr_err.first", first_err_cycle, 32'(viol_cyc));

        // Async reset mid-packet
        rst = 0;
        #1;
        chk("async_rst.in_pkt", 32'(in_pkt), 0);
        chk("async_rst.err", 32'(err_sticky), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        for (int i = 0; i < 4; i++) step("rerun");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            stif.st_ready = (($urandom % 10) != 0);
            clear = (($urandom % 40) == 0);
            random_beat();
            step("rand");
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
